// File: rtl/als_spi_responder_if.sv
// rtl/als_spi_responder_if.sv - SPI pins and sample-write handshake for the ALS responder
interface als_spi_responder_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs;
  logic              sdo;
  logic              sdo_oe;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output sclk, cs, s_data, s_valid,
    input  sdo, sdo_oe, s_ready
  );

  modport slave (
    input  sclk, cs, s_data, s_valid,
    output sdo, sdo_oe, s_ready
  );
endinterface

// File: rtl/als_spi_responder.sv
// rtl/als_spi_responder.sv - Pmod ALS SPI output emulator; optional counters via ALS_SPI_RESP_CNT_EN
module als_spi_responder #(
  parameter int LEAD_ZEROS  = 3,
  parameter int DATA_W      = 8,
  parameter int TRAIL_ZEROS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  als_spi_responder_if.slave  bus,
  output logic                frame_done,
  output logic                frame_abort,
`ifdef ALS_SPI_RESP_CNT_EN
  output logic [15:0]         frame_cnt,
  output logic [7:0]          abort_cnt,
`endif
  output logic                underrun
);

  localparam int FRAME_LEN = LEAD_ZEROS + DATA_W + TRAIL_ZEROS;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_WAIT_CS = 2'd2;

  logic              sclk_s1, sclk_s2, sclk_d;
  logic              cs_s1, cs_s2, cs_d;
  logic [1:0]        state;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] last_byte;
  logic [DATA_W-1:0] frame_byte;
  // Frame bits 1..FRAME_LEN-1; bit 0 is always a lead zero driven at load time.
  logic [FRAME_LEN-2:0] frame_sr;
  logic [4:0]        bit_cnt;
  logic [4:0]        bit_nxt;
  logic              sclk_fall, cs_fall, cs_rise;

  assign sclk_fall  = ~sclk_s2 & sclk_d;
  assign cs_fall    = ~cs_s2 & cs_d;
  assign cs_rise    = cs_s2 & ~cs_d;
  assign bit_nxt    = bit_cnt + 5'd1;
  assign frame_byte = hold_full ? hold_data : last_byte;
  assign bus.s_ready = ~hold_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1 <= 1'b1;
      sclk_s2 <= 1'b1;
      sclk_d  <= 1'b1;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
    end else begin
      sclk_s1 <= bus.sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= bus.cs;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      hold_full   <= 1'b0;
      hold_data   <= '0;
      last_byte   <= '0;
      frame_sr    <= '0;
      bit_cnt     <= '0;
      bus.sdo     <= 1'b0;
      bus.sdo_oe  <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;

      if (bus.s_valid && !hold_full) begin
        hold_data <= bus.s_data;
        hold_full <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          bus.sdo    <= 1'b0;
          bus.sdo_oe <= 1'b0;
          if (cs_fall) begin
            // A write landing in the same cycle only fills hold for the next frame.
            if (hold_full) begin
              hold_full <= 1'b0;
              last_byte <= hold_data;
            end else begin
              underrun <= 1'b1;
            end
            frame_sr   <= {{(LEAD_ZEROS-1){1'b0}}, frame_byte, {TRAIL_ZEROS{1'b0}}};
            bit_cnt    <= '0;
            bus.sdo_oe <= 1'b1;
            bus.sdo    <= 1'b0;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            bus.sdo     <= 1'b0;
            bus.sdo_oe  <= 1'b0;
            frame_abort <= 1'b1;
            state       <= ST_IDLE;
          end else if (sclk_fall) begin
            bit_cnt <= bit_nxt;
            if (bit_nxt == 5'(FRAME_LEN)) begin
              bus.sdo    <= 1'b0;
              frame_done <= 1'b1;
              state      <= ST_WAIT_CS;
            end else begin
              bus.sdo  <= frame_sr[FRAME_LEN-2];
              frame_sr <= {frame_sr[FRAME_LEN-3:0], 1'b0};
            end
          end
        end
        ST_WAIT_CS: begin
          bus.sdo <= 1'b0;
          if (cs_rise) begin
            bus.sdo_oe <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          bus.sdo    <= 1'b0;
          bus.sdo_oe <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALS_SPI_RESP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      if (frame_done)
        frame_cnt <= frame_cnt + 16'd1;
      if (frame_abort && abort_cnt != 8'hFF)
        abort_cnt <= abort_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_als_spi_responder.sv
// tb/tb_als_spi_responder.sv - directed bench for als_spi_responder
module tb_als_spi_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_done, frame_abort, underrun;
`ifdef ALS_SPI_RESP_CNT_EN
  logic [15:0] frame_cnt;
  logic [7:0]  abort_cnt;
`endif

  als_spi_responder_if #(.DATA_W(8)) bus ();

  als_spi_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
`ifdef ALS_SPI_RESP_CNT_EN
    .frame_cnt   (frame_cnt),
    .abort_cnt   (abort_cnt),
`endif
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int n_abort = 0;
  int n_under = 0;

  always @(negedge clk) begin
    if (frame_done)  n_done++;
    if (frame_abort) n_abort++;
    if (underrun)    n_under++;
  end

  localparam int HALF = 26;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.cs = 1'b1;
    bus.sclk = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    bus.s_data = d;
    bus.s_valid = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    wait_clk(2);
  endtask

  // Samples sdo just before each sclk fall, as the ALS master does.
  task automatic run_frame(input int nfalls, input bit end_cs,
                           output logic [14:0] bits, output logic b16,
                           output logic oe_ok, output logic rdy_first);
    bits = '0;
    b16 = 1'b1;
    oe_ok = 1'b1;
    @(negedge clk);
    bus.cs = 1'b0;
    wait_clk(HALF);
    rdy_first = bus.s_ready;
    for (int k = 1; k <= nfalls; k++) begin
      if (bus.sdo_oe !== 1'b1) oe_ok = 1'b0;
      if (k <= 15) bits[15-k] = bus.sdo;
      else b16 = bus.sdo;
      bus.sclk = 1'b0;
      wait_clk(HALF);
      bus.sclk = 1'b1;
      wait_clk(HALF);
    end
    if (end_cs) begin
      bus.cs = 1'b1;
      wait_clk(HALF);
    end
  endtask

  logic [14:0] bits;
  logic b16, oe_ok, rdy;
  int d0, a0, u0;

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.sdo !== 1'b0) begin n_err++; $display("FAIL reset_sdo got %b want 0", bus.sdo); end
    n_cmp++; if (bus.sdo_oe !== 1'b0) begin n_err++; $display("FAIL reset_sdo_oe got %b want 0", bus.sdo_oe); end
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready got %b want 1", bus.s_ready); end
    n_cmp++; if ({frame_done, frame_abort, underrun} !== 3'b000) begin n_err++; $display("FAIL reset_pulses got %b want 000", {frame_done, frame_abort, underrun}); end
  endtask

  task automatic test_basic();
    write_byte(8'hA5);
    n_cmp++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL basic_hold_full got %b want 0", bus.s_ready); end
    d0 = n_done; u0 = n_under;
    run_frame(16, 1'b1, bits, b16, oe_ok, rdy);
    n_cmp++; if (bits !== 15'h0A50) begin n_err++; $display("FAIL basic_bits got %h want 0a50", bits); end
    n_cmp++; if (b16 !== 1'b0) begin n_err++; $display("FAIL basic_bit16 got %b want 0", b16); end
    n_cmp++; if (oe_ok !== 1'b1) begin n_err++; $display("FAIL basic_oe got %b want 1", oe_ok); end
    n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL basic_ready_at_fall got %b want 1", rdy); end
    n_cmp++; if (n_done - d0 != 1) begin n_err++; $display("FAIL basic_done got %0d want 1", n_done - d0); end
    n_cmp++; if (n_under - u0 != 0) begin n_err++; $display("FAIL basic_underrun got %0d want 0", n_under - u0); end
    n_cmp++; if (bus.sdo_oe !== 1'b0) begin n_err++; $display("FAIL basic_oe_after_cs got %b want 0", bus.sdo_oe); end
  endtask

  task automatic test_underrun();
    write_byte(8'h3C);
    run_frame(16, 1'b1, bits, b16, oe_ok, rdy);
    n_cmp++; if (bits !== 15'h03C0) begin n_err++; $display("FAIL under_first got %h want 03c0", bits); end
    u0 = n_under;
    run_frame(16, 1'b1, bits, b16, oe_ok, rdy);
    n_cmp++; if (bits !== 15'h03C0) begin n_err++; $display("FAIL under_repeat got %h want 03c0", bits); end
    n_cmp++; if (n_under - u0 != 1) begin n_err++; $display("FAIL under_pulse got %0d want 1", n_under - u0); end
    do_reset();
    u0 = n_under;
    run_frame(16, 1'b1, bits, b16, oe_ok, rdy);
    n_cmp++; if (bits !== 15'h0000) begin n_err++; $display("FAIL under_reset_bits got %h want 0000", bits); end
    n_cmp++; if (n_under - u0 != 1) begin n_err++; $display("FAIL under_reset_pulse got %0d want 1", n_under - u0); end
  endtask

  task automatic test_abort();
    write_byte(8'hFF);
    d0 = n_done; a0 = n_abort;
    run_frame(6, 1'b0, bits, b16, oe_ok, rdy);
    @(negedge clk);
    bus.cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.sdo_oe !== 1'b0) begin n_err++; $display("FAIL abort_oe got %b want 0", bus.sdo_oe); end
    wait_clk(HALF);
    n_cmp++; if (n_abort - a0 != 1) begin n_err++; $display("FAIL abort_pulse got %0d want 1", n_abort - a0); end
    n_cmp++; if (n_done - d0 != 0) begin n_err++; $display("FAIL abort_no_done got %0d want 0", n_done - d0); end
    u0 = n_under;
    run_frame(16, 1'b1, bits, b16, oe_ok, rdy);
    n_cmp++; if (bits !== 15'h0FF0) begin n_err++; $display("FAIL abort_next_bits got %h want 0ff0", bits); end
    n_cmp++; if (n_under - u0 != 1) begin n_err++; $display("FAIL abort_next_under got %0d want 1", n_under - u0); end
  endtask

  task automatic test_back_to_back();
    write_byte(8'h11);
    n_cmp++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b want 0", bus.s_ready); end
    write_byte(8'h22);
    run_frame(16, 1'b1, bits, b16, oe_ok, rdy);
    n_cmp++; if (bits !== 15'h0110) begin n_err++; $display("FAIL bp_bits got %h want 0110", bits); end
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after got %b want 1", bus.s_ready); end
  endtask

  task automatic test_reset_mid_frame();
    write_byte(8'hA5);
    run_frame(8, 1'b0, bits, b16, oe_ok, rdy);
    write_byte(8'h77);
    n_cmp++; if ({bus.sdo_oe, bus.sdo} !== 2'b11) begin n_err++; $display("FAIL rstmid_pre got %b want 11", {bus.sdo_oe, bus.sdo}); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.sdo_oe !== 1'b0) begin n_err++; $display("FAIL rstmid_oe got %b want 0", bus.sdo_oe); end
    n_cmp++; if (bus.sdo !== 1'b0) begin n_err++; $display("FAIL rstmid_sdo got %b want 0", bus.sdo); end
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", bus.s_ready); end
    bus.cs = 1'b1;
    bus.sclk = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    u0 = n_under;
    run_frame(16, 1'b1, bits, b16, oe_ok, rdy);
    n_cmp++; if (bits !== 15'h0000) begin n_err++; $display("FAIL rstmid_bits got %h want 0000", bits); end
    n_cmp++; if (n_under - u0 != 1) begin n_err++; $display("FAIL rstmid_under got %0d want 1", n_under - u0); end
  endtask

`ifdef ALS_SPI_RESP_CNT_EN
  task automatic test_counters();
    do_reset();
    for (int i = 0; i < 3; i++) run_frame(16, 1'b1, bits, b16, oe_ok, rdy);
    for (int i = 0; i < 2; i++) begin
      run_frame(4, 1'b0, bits, b16, oe_ok, rdy);
      @(negedge clk);
      bus.cs = 1'b1;
      wait_clk(HALF);
    end
    n_cmp++; if (frame_cnt !== 16'd3) begin n_err++; $display("FAIL cnt_frames got %0d want 3", frame_cnt); end
    n_cmp++; if (abort_cnt !== 8'd2) begin n_err++; $display("FAIL cnt_aborts got %0d want 2", abort_cnt); end
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    run_frame(16, 1'b1, bits, b16, oe_ok, rdy);
    n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL cnt_wrap got %h want 0000", frame_cnt); end
  endtask
`endif

  initial begin
    bus.cs = 1'b1;
    bus.sclk = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    test_reset();
    test_basic();
    test_underrun();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef ALS_SPI_RESP_CNT_EN
    test_counters();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/als_spi_responder.md
Name: als_spi_responder

Overview:
- SPI responder that emulates the Pmod ALS ADC output end of the link.
- The host-side SPI master drives cs and sclk. This block answers with a 15-bit serial frame on sdo: 3 leading zeros, an 8-bit light value MSB first, then 4 trailing zeros.
- Used as a bench/board stand-in for the sensor, so the team's SPI receiver can be exercised with known data.
- sclk and cs are sampled asynchronously into the 100 MHz clk domain.

Parameters:
- LEAD_ZEROS, 3, zero bits driven before data
- DATA_W, 8, data bits per frame, MSB first
- TRAIL_ZEROS, 4, zero bits driven after data

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous active-low reset
- sclk  input  1  SPI clock from master, asynchronous to clk, idle high
- cs  input  1  SPI chip select from master, active low, asynchronous
- sdo  output  1  serial data to master
- sdo_oe  output  1  high while sdo is actively driven (cs low); pad tri-state control
- s_data  input  DATA_W  next sample value
- s_valid  input  1  s_data valid
- s_ready  output  1  holding register empty
- frame_done  output  1  one-clk pulse, full frame shifted
- frame_abort  output  1  one-clk pulse, cs rose mid-frame
- underrun  output  1  one-clk pulse, frame started with empty holding register

Behaviour:
- **Interface (already decided):** one clock; reset is asynchronous and active-low.
- **Reset values:**
  - sdo=0, sdo_oe=0, s_ready=1, frame_done=0, frame_abort=0, underrun=0.
  - Holding register empty; last_byte=0; state IDLE.
  - Synchronizers reset to sclk=1, cs=1.
- **Synchronizers:**
  - sclk and cs each pass through 2 flops, then a delay flop for edge detect.
  - A fall is detected when synced=0 and delayed=1.
  - Registered outputs change 3 clk edges after the input transition is first captured. Master SCLK half-period must be at least 8 clk.
- **Holding register (one deep):**
  - s_ready = ~hold_full.
  - s_valid & s_ready captures s_data and sets hold_full.
  - s_valid while s_ready=0 is ignored.
- **FRAME_LEN = LEAD_ZEROS+DATA_W+TRAIL_ZEROS** (15). bit_cnt is 5 bits wide.
- **IDLE:**
  - sdo_oe=0, sdo=0.
  - On cs fall:
    - If hold_full: use hold_data, clear hold_full, set last_byte = hold_data.
    - Else: reuse last_byte and pulse underrun.
  - Load the frame shift register {zeros, byte, zeros}, set bit_cnt=0, sdo_oe=1, sdo=frame bit 0 (a lead zero). Go to SHIFT.
  - If a write and a cs fall occur in the same cycle, the write is stored in hold. If hold was empty, the frame uses last_byte and underrun pulses.
- **SHIFT:**
  - Each sclk fall increments bit_cnt.
  - While bit_cnt+1 < FRAME_LEN: sdo = frame bit bit_cnt+1.
  - On the fall where bit_cnt+1 == FRAME_LEN: sdo=0, pulse frame_done, go to WAIT_CS.
  - Data MSB therefore appears after fall LEAD_ZEROS (3) and LSB after fall 10.
  - sclk rising edges are ignored.
  - cs rise before completion: sdo_oe=0, sdo=0, pulse frame_abort, go to IDLE. The consumed byte is not restored.
- **WAIT_CS:**
  - sdo held 0 and sdo_oe held 1.
  - Additional sclk falls are ignored. A 16th master clock reads 0.
  - cs rise: sdo_oe=0, go to IDLE.
- **Simultaneous events:** a cs rise and an sclk fall detected in the same cycle resolve as the cs rise; the fall is discarded.
- **sclk with cs high:** ignored entirely.
- **Reset mid-frame:** all state returns to reset values immediately, hold data is lost, sdo_oe drops asynchronously.

Optional Feature:
- Macro ALS_SPI_RESP_CNT_EN.
- **When defined:**
  - Adds output frame_cnt[15:0], reset 0.
  - Increments on every frame_done and wraps 0xFFFF→0.
  - Adds output abort_cnt[7:0], which increments on frame_abort and saturates at 0xFF.
- **When undefined:** neither port nor counter exists; all other behaviour is identical.

Test Plan:
- **Basic frame:** reset; write 0xA5; master drops cs and gives 16 sclk cycles (SCLK about 1.92 MHz) → bits sampled on falls 1..15 read 000_10100101_0000; frame_done pulses once; s_ready returns to 1 at the cs fall.
- **Underrun:** send frame 0x3C, then start a second frame with no write → second frame carries 0x3C and underrun pulses once. Repeat from reset with no write → data 0x00 and underrun pulses.
- **Abort:** write 0xFF; raise cs after 6 sclk falls → frame_abort pulses, sdo_oe=0 within 3 clk, no frame_done. The next frame with no write carries 0xFF plus underrun.
- **Back-pressure:** write 0x11 then 0x22 without a frame in between → the second write is ignored while s_ready=0; the frame carries 0x11.
- **Reset mid-frame:** deassert rst_n after 8 falls → sdo_oe and sdo go to 0 immediately, s_ready=1. A frame after reset carries 0x00 with underrun.
- **Counter (with ALS_SPI_RESP_CNT_EN):** 3 full frames and 2 aborts → frame_cnt=3, abort_cnt=2. Preload via force to 0xFFFF, then one frame → frame_cnt=0.
